lcd_timing_gen: RTL and testbench
=================================

# lcd_timing_gen

Parametrised display timing generator for the LVDS pattern path. It produces HSYNC, VSYNC, DE, active-area pixel coordinates and frame/line start strobes from one clock, with configurable porch/pulse geometry, sync polarity and a clock-enable. An optional shadow-register interface reprograms geometry at runtime, applied atomically at the frame boundary. It sits between the clock/reset block and the pattern generators, which consume the coordinates and DE.

## Interface
- H_PIXEL, 1920: active pixels per line
- H_FRONT, 88: horizontal front porch, clocks
- H_PULSE, 44: HSYNC width, clocks
- H_BACK, 148: horizontal back porch, clocks
- V_PIXEL, 1080: active lines per frame
- V_FRONT, 4: vertical front porch, lines
- V_PULSE, 5: VSYNC width, lines
- V_BACK, 36: vertical back porch, lines
- HS_POL, 1'b0: HSYNC asserted level
- VS_POL, 1'b0: VSYNC asserted level
- COORD_W, 12: counter/coordinate width; every total must fit
- iclk  in  1  pixel clock, all logic on rising edge
- irst  in  1  reset, synchronous, active-high
- iena  in  1  clock enable; low freezes counters and all outputs
- icfg_load  in  1  capture icfg_* into shadow (TG_RUNTIME_CFG_EN only)
- icfg_h_pixel, icfg_h_front, icfg_h_pulse, icfg_h_back, icfg_v_pixel, icfg_v_front, icfg_v_pulse, icfg_v_back  in  COORD_W each  runtime geometry (TG_RUNTIME_CFG_EN only)
- ocfg_pending  out  1  shadow loaded, not yet applied (TG_RUNTIME_CFG_EN only)
- ohsync  out  1  horizontal sync
- ovsync  out  1  vertical sync
- ode  out  1  data enable
- ox_coord  out  COORD_W  active x, 0 outside DE
- oy_coord  out  COORD_W  active y, 0 outside vertical active
- oframe_start  out  1  one-cycle strobe at (h=0,v=0)
- oline_start  out  1  one-cycle strobe at h=0

## Operation
- H_TOTAL = H_PULSE+H_BACK+H_PIXEL+H_FRONT; V_TOTAL likewise in lines.
- Line order: sync, back porch, active, front porch; same for frame.
- h_cnt counts 0..H_TOTAL-1 on each enabled edge and wraps to 0; v_cnt increments when h_cnt wraps, and wraps 0 after V_TOTAL-1.
- ohsync = HS_POL when h_cnt < H_PULSE, else ~HS_POL. ovsync = VS_POL when v_cnt < V_PULSE (whole lines), else ~VS_POL.
- Vertical active: V_PULSE+V_BACK ≤ v_cnt < V_PULSE+V_BACK+V_PIXEL; horizontal active analogous. ode = both.
- ox_coord = h_cnt−(H_PULSE+H_BACK) while ode, else 0. oy_coord = v_cnt−(V_PULSE+V_BACK) during vertical active lines (all clocks of the line), else 0.
- Arithmetic unsigned, COORD_W bits, no overflow by construction.

## Timing
- All outputs registered; output values reflect the counter state at the previous enabled edge (latency 1 enabled clock).
- Reset: counters 0; ohsync=~HS_POL, ovsync=~VS_POL, ode=0, coords 0, strobes 0, ocfg_pending=0, shadow and active geometry = parameters.
- First enabled edge after reset release: outputs reflect (0,0): syncs asserted, oframe_start=1, oline_start=1.
- iena low: counters, outputs and strobes hold (strobes that are high stay high; consumers qualify with iena).
- Reset mid-frame: next edge forces reset values regardless of iena.

## Configuration
- TG_RUNTIME_CFG_EN defined: icfg_* ports and ocfg_pending exist. icfg_load high on any edge copies icfg_* into shadow and sets ocfg_pending; repeated loads overwrite. Shadow moves to active geometry on the enabled edge where h_cnt=H_TOTAL−1 and v_cnt=V_TOTAL−1, clearing ocfg_pending; load coincident with that edge is taken into shadow and stays pending for the next boundary. Zero field values are replaced by 1.
- Undefined: ports absent, geometry fixed to parameters.

## Test plan
Bench geometry H 2/3/8/1 (total 14), V 1/2/4/1 (total 8), 112 clocks/frame, iena=1.
- Release reset -> edge 1: ohsync=ovsync=0, oframe_start=1; ohsync deasserts at edge 3; ovsync deasserts at edge 15.
- Free run -> ode first high edge 48, ox_coord 0..7, oy_coord=0; 32 DE clocks per frame; oframe_start every 112 edges.
- iena toggled low 5 clocks mid-DE -> outputs frozen, ox_coord resumes next value, frame period 117 clocks.
- irst pulsed at edge 60 -> reset values next edge, sequence restarts identical to first scenario.
- TG_RUNTIME_CFG_EN: load H_PIXEL=4 mid-frame -> ocfg_pending=1 until frame wrap, next frame H_TOTAL=10, ode 4 clocks/line.
- HS_POL=VS_POL=1 -> syncs high-true, all other timing unchanged.

Source files
------------

// File: rtl/lcd_timing_gen_if.sv
// lcd_timing_gen_if
// -----------------------------------------------------------------------------
// Bundles the timing generator's enable input, its video timing outputs and,
// when TG_RUNTIME_CFG_EN is defined, the runtime geometry programming port.
// Clock and reset are plain ports on the generator, not part of this bundle.
//
// Members:
//   iena           clock enable into the generator; low freezes everything
//   ohsync/ovsync  sync outputs, polarity set by the generator's parameters
//   ode            data enable (horizontal and vertical active)
//   ox_coord       active x coordinate, 0 outside DE
//   oy_coord       active y coordinate, 0 outside vertical active lines
//   oframe_start   strobe for the first clock of a frame
//   oline_start    strobe for the first clock of a line
//   icfg_*         shadow geometry load port      (TG_RUNTIME_CFG_EN only)
//   ocfg_pending   shadow loaded but not applied   (TG_RUNTIME_CFG_EN only)
//
// Modports: master = the timing generator, slave = a consumer/driver of it.
// Optional feature macro: TG_RUNTIME_CFG_EN
// -----------------------------------------------------------------------------
interface lcd_timing_gen_if #(
  parameter int COORD_W = 12
);
  logic               iena;
  logic               ohsync;
  logic               ovsync;
  logic               ode;
  logic [COORD_W-1:0] ox_coord;
  logic [COORD_W-1:0] oy_coord;
  logic               oframe_start;
  logic               oline_start;

`ifdef TG_RUNTIME_CFG_EN
  logic               icfg_load;
  logic [COORD_W-1:0] icfg_h_pixel;
  logic [COORD_W-1:0] icfg_h_front;
  logic [COORD_W-1:0] icfg_h_pulse;
  logic [COORD_W-1:0] icfg_h_back;
  logic [COORD_W-1:0] icfg_v_pixel;
  logic [COORD_W-1:0] icfg_v_front;
  logic [COORD_W-1:0] icfg_v_pulse;
  logic [COORD_W-1:0] icfg_v_back;
  logic               ocfg_pending;

  modport master (
    input  iena, icfg_load,
    input  icfg_h_pixel, icfg_h_front, icfg_h_pulse, icfg_h_back,
    input  icfg_v_pixel, icfg_v_front, icfg_v_pulse, icfg_v_back,
    output ohsync, ovsync, ode, ox_coord, oy_coord, oframe_start, oline_start,
    output ocfg_pending
  );

  modport slave (
    output iena, icfg_load,
    output icfg_h_pixel, icfg_h_front, icfg_h_pulse, icfg_h_back,
    output icfg_v_pixel, icfg_v_front, icfg_v_pulse, icfg_v_back,
    input  ohsync, ovsync, ode, ox_coord, oy_coord, oframe_start, oline_start,
    input  ocfg_pending
  );
`else
  modport master (
    input  iena,
    output ohsync, ovsync, ode, ox_coord, oy_coord, oframe_start, oline_start
  );

  modport slave (
    output iena,
    input  ohsync, ovsync, ode, ox_coord, oy_coord, oframe_start, oline_start
  );
`endif
endinterface

// File: rtl/lcd_timing_gen.sv
// lcd_timing_gen
// -----------------------------------------------------------------------------
// Display timing generator for the LVDS pattern path. Two counters walk the
// frame (h_cnt across a line, v_cnt across lines) in the order sync, back
// porch, active, front porch. Every output is registered from the counter
// state present at the enabled edge, so outputs lag the counters by one
// enabled clock.
//
// Ports:
//   iclk   pixel clock, everything on the rising edge
//   irst   synchronous active-high reset
//   tg     lcd_timing_gen_if.master: iena in, hsync/vsync/de/coords/strobes
//          out, plus the runtime geometry port when the feature is enabled
//
// Optional feature macro: TG_RUNTIME_CFG_EN
//   Defined   - geometry can be reprogrammed through a shadow register that is
//               copied into the active geometry on the last clock of a frame.
//   Undefined - geometry is fixed to the parameters.
// -----------------------------------------------------------------------------
module lcd_timing_gen #(
  parameter int   H_PIXEL = 1920,
  parameter int   H_FRONT = 88,
  parameter int   H_PULSE = 44,
  parameter int   H_BACK  = 148,
  parameter int   V_PIXEL = 1080,
  parameter int   V_FRONT = 4,
  parameter int   V_PULSE = 5,
  parameter int   V_BACK  = 36,
  parameter logic HS_POL  = 1'b0,
  parameter logic VS_POL  = 1'b0,
  parameter int   COORD_W = 12
) (
  input logic              iclk,
  input logic              irst,
  lcd_timing_gen_if.master tg
);

  typedef struct packed {
    logic [COORD_W-1:0] h_pulse;
    logic [COORD_W-1:0] h_back;
    logic [COORD_W-1:0] h_pixel;
    logic [COORD_W-1:0] h_front;
    logic [COORD_W-1:0] v_pulse;
    logic [COORD_W-1:0] v_back;
    logic [COORD_W-1:0] v_pixel;
    logic [COORD_W-1:0] v_front;
  } geom_t;

  localparam geom_t PARAM_GEO = geom_t'({
    COORD_W'(H_PULSE), COORD_W'(H_BACK), COORD_W'(H_PIXEL), COORD_W'(H_FRONT),
    COORD_W'(V_PULSE), COORD_W'(V_BACK), COORD_W'(V_PIXEL), COORD_W'(V_FRONT)
  });

  geom_t              geo;
  logic [COORD_W-1:0] h_cnt;
  logic [COORD_W-1:0] v_cnt;
  logic [COORD_W-1:0] h_act_start;
  logic [COORD_W-1:0] h_act_end;
  logic [COORD_W-1:0] h_total;
  logic [COORD_W-1:0] v_act_start;
  logic [COORD_W-1:0] v_act_end;
  logic [COORD_W-1:0] v_total;
  logic               h_last;
  logic               v_last;
  logic               in_h_act;
  logic               in_v_act;

  // Region boundaries follow the sync, back porch, active, front porch order,
  // so each boundary is the running sum of the fields before it.
  assign h_act_start = geo.h_pulse + geo.h_back;
  assign h_act_end   = h_act_start + geo.h_pixel;
  assign h_total     = h_act_end + geo.h_front;
  assign v_act_start = geo.v_pulse + geo.v_back;
  assign v_act_end   = v_act_start + geo.v_pixel;
  assign v_total     = v_act_end + geo.v_front;

  // ">=" rather than "==" so a counter can never run past the end of a line
  // or frame and wander through the full counter range.
  assign h_last   = (h_cnt >= h_total - COORD_W'(1));
  assign v_last   = (v_cnt >= v_total - COORD_W'(1));
  assign in_h_act = (h_cnt >= h_act_start) && (h_cnt < h_act_end);
  assign in_v_act = (v_cnt >= v_act_start) && (v_cnt < v_act_end);

`ifdef TG_RUNTIME_CFG_EN
  geom_t shadow_geo;
  geom_t load_geo;
  logic  pending;
  logic  frame_last;

  // A zero-length region would break the counter wrap, so zero fields are
  // promoted to one before they reach the shadow.
  function automatic logic [COORD_W-1:0] non_zero(input logic [COORD_W-1:0] val);
    return (val == '0) ? COORD_W'(1) : val;
  endfunction

  assign load_geo = geom_t'({
    non_zero(tg.icfg_h_pulse), non_zero(tg.icfg_h_back),
    non_zero(tg.icfg_h_pixel), non_zero(tg.icfg_h_front),
    non_zero(tg.icfg_v_pulse), non_zero(tg.icfg_v_back),
    non_zero(tg.icfg_v_pixel), non_zero(tg.icfg_v_front)
  });

  assign frame_last      = h_last && v_last;
  assign tg.ocfg_pending = pending;

  // Shadow capture happens on any edge, independent of iena. The shadow is
  // copied into the active geometry only on the enabled edge that closes a
  // frame, so the counters restart at (0,0) with a consistent geometry. The
  // load check comes second so a load on that same edge lands in the shadow
  // and stays pending for the following frame boundary.
  always_ff @(posedge iclk) begin
    if (irst) begin
      geo        <= PARAM_GEO;
      shadow_geo <= PARAM_GEO;
      pending    <= 1'b0;
    end else begin
      if (tg.iena && frame_last) begin
        geo     <= shadow_geo;
        pending <= 1'b0;
      end
      if (tg.icfg_load) begin
        shadow_geo <= load_geo;
        pending    <= 1'b1;
      end
    end
  end
`else
  assign geo = PARAM_GEO;
`endif

  // Main timing process. Outputs are decoded from the counter values present
  // at this edge, then the counters advance, which gives the one-clock output
  // latency. With iena low nothing moves, including the strobes, so a strobe
  // that was high stays high until the next enabled edge.
  always_ff @(posedge iclk) begin
    if (irst) begin
      h_cnt           <= '0;
      v_cnt           <= '0;
      tg.ohsync       <= ~HS_POL;
      tg.ovsync       <= ~VS_POL;
      tg.ode          <= 1'b0;
      tg.ox_coord     <= '0;
      tg.oy_coord     <= '0;
      tg.oframe_start <= 1'b0;
      tg.oline_start  <= 1'b0;
    end else if (tg.iena) begin
      tg.ohsync       <= (h_cnt < geo.h_pulse) ? HS_POL : ~HS_POL;
      tg.ovsync       <= (v_cnt < geo.v_pulse) ? VS_POL : ~VS_POL;
      tg.ode          <= in_h_act && in_v_act;
      tg.ox_coord     <= (in_h_act && in_v_act) ? (h_cnt - h_act_start) : '0;
      tg.oy_coord     <= in_v_act ? (v_cnt - v_act_start) : '0;
      tg.oframe_start <= (h_cnt == '0) && (v_cnt == '0);
      tg.oline_start  <= (h_cnt == '0);

      if (h_last) begin
        h_cnt <= '0;
        v_cnt <= v_last ? '0 : v_cnt + COORD_W'(1);
      end else begin
        h_cnt <= h_cnt + COORD_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_lcd_timing_gen.sv
// tb_lcd_timing_gen
// -----------------------------------------------------------------------------
// Bench for lcd_timing_gen using a small geometry (H 2/3/8/1, V 1/2/4/1).
// Two instances share stimulus: one with low-true syncs and one with
// high-true syncs. The reference model tracks a single linear position within
// the frame and derives line/row, regions and coordinates from it with plain
// arithmetic. Directed sequences cover the reset release, free run, an iena
// gap and a mid-frame reset; a randomized phase follows.
// Optional feature macro: TG_RUNTIME_CFG_EN (adds the runtime geometry checks)
// -----------------------------------------------------------------------------
module tb_lcd_timing_gen;

  localparam int COORD_W = 12;
  // geometry index order: 0 hpulse, 1 hback, 2 hpixel, 3 hfront,
  //                       4 vpulse, 5 vback, 6 vpixel, 7 vfront
  localparam int P_HS = 2, P_HB = 3, P_HP = 8, P_HF = 1;
  localparam int P_VS = 1, P_VB = 2, P_VP = 4, P_VF = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  lcd_timing_gen_if #(.COORD_W(COORD_W)) tg ();
  lcd_timing_gen_if #(.COORD_W(COORD_W)) tg_pol ();

  lcd_timing_gen #(
    .H_PIXEL(P_HP), .H_FRONT(P_HF), .H_PULSE(P_HS), .H_BACK(P_HB),
    .V_PIXEL(P_VP), .V_FRONT(P_VF), .V_PULSE(P_VS), .V_BACK(P_VB),
    .HS_POL(1'b0), .VS_POL(1'b0), .COORD_W(COORD_W)
  ) dut (
    .iclk(clk),
    .irst(rst),
    .tg  (tg)
  );

  lcd_timing_gen #(
    .H_PIXEL(P_HP), .H_FRONT(P_HF), .H_PULSE(P_HS), .H_BACK(P_HB),
    .V_PIXEL(P_VP), .V_FRONT(P_VF), .V_PULSE(P_VS), .V_BACK(P_VB),
    .HS_POL(1'b1), .VS_POL(1'b1), .COORD_W(COORD_W)
  ) dut_pol (
    .iclk(clk),
    .irst(rst),
    .tg  (tg_pol)
  );

  int total_checks = 0;
  int bad_checks   = 0;

  int params [8] = '{P_HS, P_HB, P_HP, P_HF, P_VS, P_VB, P_VP, P_VF};
  int geo    [8];
  int shadow [8];
  int cfg_val[8];
  int m_pos;
  bit m_pend;

  logic e_hs, e_vs, e_de, e_fs, e_ls, e_pend;
  int   e_x, e_y;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total_checks++;
    if (observed !== expected) begin
      bad_checks++;
      $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Reference model: outputs for the current linear position, then advance.
  task automatic modelStep(input bit r, input bit en, input bit ld);
    int htot, vtot, h, v, hs0, vs0;
    bit hact, vact;
    if (r) begin
      m_pos = 0;
      geo = params;
      shadow = params;
      m_pend = 1'b0;
      e_hs = 1'b1; e_vs = 1'b1; e_de = 1'b0;
      e_x = 0; e_y = 0; e_fs = 1'b0; e_ls = 1'b0;
    end else begin
      if (en) begin
        htot = geo[0] + geo[1] + geo[2] + geo[3];
        vtot = geo[4] + geo[5] + geo[6] + geo[7];
        h    = m_pos % htot;
        v    = m_pos / htot;
        hs0  = geo[0] + geo[1];
        vs0  = geo[4] + geo[5];
        hact = (h >= hs0) && (h < hs0 + geo[2]);
        vact = (v >= vs0) && (v < vs0 + geo[6]);
        e_hs = !(h < geo[0]);
        e_vs = !(v < geo[4]);
        e_de = hact && vact;
        e_x  = (hact && vact) ? h - hs0 : 0;
        e_y  = vact ? v - vs0 : 0;
        e_fs = (m_pos == 0);
        e_ls = (h == 0);
        if (m_pos == htot * vtot - 1) begin
          m_pos  = 0;
          geo    = shadow;
          m_pend = 1'b0;
        end else begin
          m_pos++;
        end
      end
      if (ld) begin
        for (int i = 0; i < 8; i++) shadow[i] = (cfg_val[i] == 0) ? 1 : cfg_val[i];
        m_pend = 1'b1;
      end
    end
    e_pend = m_pend;
  endtask

  // One clock: drive inputs at the falling edge, let the rising edge happen,
  // compare every output at the next falling edge.
  task automatic applyStimulus(input bit r, input bit en, input bit ld);
    rst       = r;
    tg.iena   = en;
    tg_pol.iena = en;
`ifdef TG_RUNTIME_CFG_EN
    tg.icfg_load         = ld;
    tg.icfg_h_pulse      = COORD_W'(cfg_val[0]);
    tg.icfg_h_back       = COORD_W'(cfg_val[1]);
    tg.icfg_h_pixel      = COORD_W'(cfg_val[2]);
    tg.icfg_h_front      = COORD_W'(cfg_val[3]);
    tg.icfg_v_pulse      = COORD_W'(cfg_val[4]);
    tg.icfg_v_back       = COORD_W'(cfg_val[5]);
    tg.icfg_v_pixel      = COORD_W'(cfg_val[6]);
    tg.icfg_v_front      = COORD_W'(cfg_val[7]);
    tg_pol.icfg_load     = ld;
    tg_pol.icfg_h_pulse  = tg.icfg_h_pulse;
    tg_pol.icfg_h_back   = tg.icfg_h_back;
    tg_pol.icfg_h_pixel  = tg.icfg_h_pixel;
    tg_pol.icfg_h_front  = tg.icfg_h_front;
    tg_pol.icfg_v_pulse  = tg.icfg_v_pulse;
    tg_pol.icfg_v_back   = tg.icfg_v_back;
    tg_pol.icfg_v_pixel  = tg.icfg_v_pixel;
    tg_pol.icfg_v_front  = tg.icfg_v_front;
    modelStep(r, en, ld);
`else
    modelStep(r, en, 1'b0);
`endif
    @(posedge clk);
    @(negedge clk);
    checkOutput("hsync",       tg.ohsync,       e_hs);
    checkOutput("vsync",       tg.ovsync,       e_vs);
    checkOutput("de",          tg.ode,          e_de);
    checkOutput("x_coord",     tg.ox_coord,     e_x);
    checkOutput("y_coord",     tg.oy_coord,     e_y);
    checkOutput("frame_start", tg.oframe_start, e_fs);
    checkOutput("line_start",  tg.oline_start,  e_ls);
    checkOutput("hsync_pol",   tg_pol.ohsync,   !e_hs);
    checkOutput("vsync_pol",   tg_pol.ovsync,   !e_vs);
    checkOutput("de_pol",      tg_pol.ode,      e_de);
    checkOutput("x_pol",       tg_pol.ox_coord, e_x);
`ifdef TG_RUNTIME_CFG_EN
    checkOutput("cfg_pending", tg.ocfg_pending, e_pend);
`endif
  endtask

  task automatic doReset();
    applyStimulus(1'b1, 1'($urandom % 2), 1'b0);
    applyStimulus(1'b1, 1'($urandom % 2), 1'b0);
  endtask

  // Two frames of free run straight after reset release, edge 1 = first
  // edge with reset low.
  task automatic runFirstFrames(input string tag);
    int first_de = 0, second_fs = 0, de_cnt = 0;
    for (int e = 1; e <= 224; e++) begin
      applyStimulus(1'b0, 1'b1, 1'b0);
      if (e == 1) begin
        checkOutput({tag, "_e1_hsync"},  tg.ohsync, 0);
        checkOutput({tag, "_e1_vsync"},  tg.ovsync, 0);
        checkOutput({tag, "_e1_fstart"}, tg.oframe_start, 1);
        checkOutput({tag, "_e1_lstart"}, tg.oline_start, 1);
      end
      if (e == 2)  checkOutput({tag, "_e2_hsync"},  tg.ohsync, 0);
      if (e == 3)  checkOutput({tag, "_e3_hsync"},  tg.ohsync, 1);
      if (e == 14) checkOutput({tag, "_e14_vsync"}, tg.ovsync, 0);
      if (e == 15) checkOutput({tag, "_e15_vsync"}, tg.ovsync, 1);
      if (e == 55) checkOutput({tag, "_e55_x"},     tg.ox_coord, 7);
      if (tg.ode && first_de == 0) first_de = e;
      if (e <= 112 && tg.ode) de_cnt++;
      if (e > 1 && tg.oframe_start && second_fs == 0) second_fs = e;
    end
    checkOutput({tag, "_first_de_edge"},   first_de, 48);
    checkOutput({tag, "_de_per_frame"},    de_cnt, 32);
    checkOutput({tag, "_second_fs_edge"},  second_fs, 113);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int second_fs;
    tg.iena = 1'b0;
    tg_pol.iena = 1'b0;
    cfg_val = params;
`ifdef TG_RUNTIME_CFG_EN
    tg.icfg_load = 1'b0;
    tg_pol.icfg_load = 1'b0;
`endif
    @(negedge clk);

    $display("[TB] reset release and free run");
    doReset();
    runFirstFrames("run1");

    $display("[TB] iena gap of 5 clocks inside DE");
    doReset();
    second_fs = 0;
    for (int e = 1; e <= 130; e++) begin
      applyStimulus(1'b0, !(e >= 51 && e <= 55), 1'b0);
      if (e == 55) checkOutput("gap_x_frozen", tg.ox_coord, 2);
      if (e == 56) checkOutput("gap_x_resume", tg.ox_coord, 3);
      if (e > 1 && tg.oframe_start && second_fs == 0) second_fs = e;
    end
    checkOutput("gap_frame_period", second_fs - 1, 117);

    $display("[TB] reset pulsed mid-frame with iena low");
    doReset();
    for (int e = 1; e <= 59; e++) applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    runFirstFrames("run2");

`ifdef TG_RUNTIME_CFG_EN
    $display("[TB] runtime geometry load");
    begin
      int de_cnt = 0;
      doReset();
      for (int e = 1; e <= 30; e++) applyStimulus(1'b0, 1'b1, 1'b0);
      cfg_val = '{P_HS, P_HB, 4, P_HF, P_VS, P_VB, P_VP, P_VF};
      applyStimulus(1'b0, 1'b1, 1'b1);
      checkOutput("cfg_pending_set", tg.ocfg_pending, 1);
      for (int e = 32; e <= 192; e++) begin
        applyStimulus(1'b0, 1'b1, 1'b0);
        if (e == 111) checkOutput("cfg_pending_hold", tg.ocfg_pending, 1);
        if (e == 112) checkOutput("cfg_pending_clr", tg.ocfg_pending, 0);
        if (e >= 113 && tg.ode) de_cnt++;
      end
      checkOutput("cfg_de_per_frame", de_cnt, 16);
      applyStimulus(1'b0, 1'b1, 1'b0);
      checkOutput("cfg_next_fstart", tg.oframe_start, 1);
    end
`endif

    $display("[TB] randomized phase");
    doReset();
    for (int n = 0; n < 4000; n++) begin
      bit ld;
      ld = 1'b0;
`ifdef TG_RUNTIME_CFG_EN
      ld = ($urandom % 120 == 0);
      for (int i = 0; i < 8; i++) cfg_val[i] = int'($urandom_range(0, 6));
`endif
      applyStimulus(($urandom % 250 == 0), ($urandom % 5 != 0), ld);
    end

    $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
    $finish;
  end

endmodule
